// File: rtl/ddr_ring_ctrl.sv
// ddr_ring_ctrl: ring-buffer address controller for DDR staging between the
// AD FIFO (burst writer) and the XB FIFO (word reader). The DDR word space is
// split into 2**BANK_BITS equal banks. Only fully written banks are readable.
module ddr_ring_ctrl #(
    parameter int unsigned AW        = 10,
    parameter int unsigned BURST     = 8,
    parameter int unsigned BANK_BITS = 1,
    parameter int unsigned CW        = 8
) (
    input  logic                 clk_150_0,
    input  logic                 reset_syn,
    input  logic                 flush,
    input  logic                 wr_go,
    input  logic                 rd_go,
    input  logic                 write_req,
    input  logic                 fifo_xb_empty,
    output logic                 wr_room,
    output logic                 rd_avail,
    output logic                 xb_refill,
    output logic [AW-1:0]        ddr_addr,
    output logic [BANK_BITS:0]   fill_banks,
    output logic [AW-1:0]        wr_ptr_out,
    output logic [AW-1:0]        rd_ptr_out,
    output logic                 ovf,
    output logic                 unf,
    output logic [CW-1:0]        ovf_cnt,
    output logic [CW-1:0]        unf_cnt
);

    // Width of the in-bank word offset and of the bank fill counter.
    localparam int unsigned BW         = AW - BANK_BITS;
    localparam int unsigned FW         = BANK_BITS + 1;
    localparam int unsigned NBANK      = 1 << BANK_BITS;
    localparam int unsigned BANK_WORDS = 1 << BW;
    // Offset of the last burst inside a bank.
    localparam int unsigned LAST_BURST = BANK_WORDS - BURST;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [FW-1:0] fill;

    logic wr_fire;
    logic rd_fire;
    logic wr_done;
    logic rd_done;
    logic wr_err;
    logic rd_err;
    logic fill_full;
    logic fill_empty;

    // Flow-control flags derive from the registered fill level only.
    assign fill_full  = (fill == FW'(NBANK));
    assign fill_empty = (fill == '0);
    assign wr_room    = !fill_full;
    assign rd_avail   = !fill_empty;

    // Accepted transfers and rejected requests.
    assign wr_fire = wr_go & wr_room;
    assign rd_fire = rd_go & rd_avail;
    assign wr_err  = wr_go & !wr_room;
    assign rd_err  = rd_go & !rd_avail;

    // A bank completes on its final burst (writer) or final word (reader).
    assign wr_done = wr_fire & (wr_ptr[BW-1:0] == BW'(LAST_BURST));
    assign rd_done = rd_fire & (&rd_ptr[BW-1:0]);

    // Write and read pointers; both wrap naturally at 2**AW.
    always_ff @(posedge clk_150_0 or posedge reset_syn) begin
        if (reset_syn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + AW'(BURST);
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    // Completed-unread bank count; simultaneous completion cancels out.
    always_ff @(posedge clk_150_0 or posedge reset_syn) begin
        if (reset_syn) begin
            fill <= '0;
        end else if (flush) begin
            fill <= '0;
        end else begin
            case ({wr_done, rd_done})
                2'b10: if (!fill_full) fill <= fill + FW'(1);
                2'b01: if (!fill_empty) fill <= fill - FW'(1);
                default: fill <= fill;
            endcase
        end
    end

    // Sticky overflow flag and saturating count.
    always_ff @(posedge clk_150_0 or posedge reset_syn) begin
        if (reset_syn) begin
            ovf     <= 1'b0;
            ovf_cnt <= '0;
        end else if (flush) begin
            ovf     <= 1'b0;
            ovf_cnt <= '0;
        end else if (wr_err) begin
            ovf <= 1'b1;
            if (ovf_cnt != '1) begin
                ovf_cnt <= ovf_cnt + CW'(1);
            end
        end
    end

    // Sticky underflow flag and saturating count.
    always_ff @(posedge clk_150_0 or posedge reset_syn) begin
        if (reset_syn) begin
            unf     <= 1'b0;
            unf_cnt <= '0;
        end else if (flush) begin
            unf     <= 1'b0;
            unf_cnt <= '0;
        end else if (rd_err) begin
            unf <= 1'b1;
            if (unf_cnt != '1) begin
                unf_cnt <= unf_cnt + CW'(1);
            end
        end
    end

    // DDR address uses the pointer value before this cycle's advance.
    always_ff @(posedge clk_150_0 or posedge reset_syn) begin
        if (reset_syn) begin
            ddr_addr  <= '0;
            xb_refill <= 1'b0;
        end else if (flush) begin
            ddr_addr  <= '0;
            xb_refill <= 1'b0;
        end else begin
            ddr_addr  <= write_req ? wr_ptr : rd_ptr;
            xb_refill <= rd_avail & fifo_xb_empty;
        end
    end

    assign wr_ptr_out = wr_ptr;
    assign rd_ptr_out = rd_ptr;
    assign fill_banks = fill;

endmodule

// File: tb/tb_ddr_ring_ctrl.sv
// Bench for ddr_ring_ctrl: directed scenarios plus randomized traffic checked
// against a word-count model of the ring buffer.
module tb_ddr_ring_ctrl;

    localparam int unsigned AW        = 10;
    localparam int unsigned BURST     = 8;
    localparam int unsigned BANK_BITS = 1;
    localparam int unsigned CW        = 8;
    localparam longint      BANK_W    = 512;
    localparam longint      SPACE     = 1024;
    localparam int          NB        = 2;

    logic                 clk_150_0;
    logic                 reset_syn;
    logic                 flush;
    logic                 wr_go;
    logic                 rd_go;
    logic                 write_req;
    logic                 fifo_xb_empty;
    logic                 wr_room;
    logic                 rd_avail;
    logic                 xb_refill;
    logic [AW-1:0]        ddr_addr;
    logic [BANK_BITS:0]   fill_banks;
    logic [AW-1:0]        wr_ptr_out;
    logic [AW-1:0]        rd_ptr_out;
    logic                 ovf;
    logic                 unf;
    logic [CW-1:0]        ovf_cnt;
    logic [CW-1:0]        unf_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: total words ever written/read since last clear.
    longint m_wr_tot;
    longint m_rd_tot;
    int     m_ovf, m_unf, m_ovf_c, m_unf_c;
    int     m_addr, m_refill;

    ddr_ring_ctrl #(.AW(AW), .BURST(BURST), .BANK_BITS(BANK_BITS), .CW(CW)) dut (
        .clk_150_0     (clk_150_0),
        .reset_syn     (reset_syn),
        .flush         (flush),
        .wr_go         (wr_go),
        .rd_go         (rd_go),
        .write_req     (write_req),
        .fifo_xb_empty (fifo_xb_empty),
        .wr_room       (wr_room),
        .rd_avail      (rd_avail),
        .xb_refill     (xb_refill),
        .ddr_addr      (ddr_addr),
        .fill_banks    (fill_banks),
        .wr_ptr_out    (wr_ptr_out),
        .rd_ptr_out    (rd_ptr_out),
        .ovf           (ovf),
        .unf           (unf),
        .ovf_cnt       (ovf_cnt),
        .unf_cnt       (unf_cnt)
    );

    initial clk_150_0 = 1'b0;
    always #5 clk_150_0 = ~clk_150_0;

    function automatic int m_fill();
        return int'(m_wr_tot / BANK_W - m_rd_tot / BANK_W);
    endfunction

    task automatic model_clear();
        m_wr_tot = 0; m_rd_tot = 0;
        m_ovf = 0; m_unf = 0; m_ovf_c = 0; m_unf_c = 0;
        m_addr = 0; m_refill = 0;
    endtask

    // Advance the model by one clock with the given inputs.
    task automatic model_step(input logic w, input logic r, input logic wq,
                              input logic e, input logic f);
        int  fl;
        bit  room, avail;
        if (f) begin
            model_clear();
        end else begin
            fl    = m_fill();
            room  = (fl != NB);
            avail = (fl != 0);
            m_addr   = int'(wq ? (m_wr_tot % SPACE) : (m_rd_tot % SPACE));
            m_refill = (avail && e) ? 1 : 0;
            if (w && room) m_wr_tot += BURST;
            else if (w) begin
                m_ovf = 1;
                if (m_ovf_c < 255) m_ovf_c++;
            end
            if (r && avail) m_rd_tot += 1;
            else if (r) begin
                m_unf = 1;
                if (m_unf_c < 255) m_unf_c++;
            end
        end
    endtask

    // Drive one cycle of inputs, keep the model in step, sample after the edge.
    task automatic cyc(input logic w, input logic r, input logic wq,
                       input logic e, input logic f);
        wr_go = w; rd_go = r; write_req = wq; fifo_xb_empty = e; flush = f;
        model_step(w, r, wq, e, f);
        @(posedge clk_150_0);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_flush();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        wr_go = 0; rd_go = 0; write_req = 0; fifo_xb_empty = 0; flush = 0;
        reset_syn = 1'b1;
        model_clear();
        repeat (3) @(posedge clk_150_0);
        #1;
        reset_syn = 1'b0;
        checks++;
        if ({wr_room, rd_avail, xb_refill, ovf, unf} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_flags got %b want 10000", {wr_room, rd_avail, xb_refill, ovf, unf});
        end
        checks++;
        if (ddr_addr !== '0 || fill_banks !== '0 || wr_ptr_out !== '0 || rd_ptr_out !== '0 ||
            ovf_cnt !== '0 || unf_cnt !== '0) begin
            errors++;
            $display("FAIL reset_regs addr=%0d fill=%0d wp=%0d rp=%0d oc=%0d uc=%0d want all 0",
                     ddr_addr, fill_banks, wr_ptr_out, rd_ptr_out, ovf_cnt, unf_cnt);
        end
        // Reset in the middle of a bank discards the partial progress.
        repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (wr_ptr_out !== 10'd24) begin
            errors++;
            $display("FAIL reset_pre_wp got %0d want 24", wr_ptr_out);
        end
        #2 reset_syn = 1'b1;
        #1;
        checks++;
        if (wr_ptr_out !== '0 || fill_banks !== '0) begin
            errors++;
            $display("FAIL reset_midburst wp=%0d fill=%0d want 0 0", wr_ptr_out, fill_banks);
        end
        @(posedge clk_150_0);
        #1;
        reset_syn = 1'b0;
        model_clear();
    endtask

    task automatic test_fill_first_bank();
        repeat (63) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (fill_banks !== 2'd0 || wr_ptr_out !== 10'd504 || rd_avail !== 1'b0) begin
            errors++;
            $display("FAIL t1_partial fill=%0d wp=%0d avail=%b want 0 504 0",
                     fill_banks, wr_ptr_out, rd_avail);
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (fill_banks !== 2'd1 || wr_ptr_out !== 10'd512 || rd_avail !== 1'b1) begin
            errors++;
            $display("FAIL t1_bank fill=%0d wp=%0d avail=%b want 1 512 1",
                     fill_banks, wr_ptr_out, rd_avail);
        end
    endtask

    task automatic test_overflow();
        repeat (64) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (fill_banks !== 2'd2 || wr_room !== 1'b0 || wr_ptr_out !== '0) begin
            errors++;
            $display("FAIL t2_full fill=%0d room=%b wp=%0d want 2 0 0", fill_banks, wr_room, wr_ptr_out);
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ovf !== 1'b1 || ovf_cnt !== 8'd1 || wr_ptr_out !== '0 || fill_banks !== 2'd2) begin
            errors++;
            $display("FAIL t2_ovf ovf=%b cnt=%0d wp=%0d fill=%0d want 1 1 0 2",
                     ovf, ovf_cnt, wr_ptr_out, fill_banks);
        end
    endtask

    task automatic test_drain();
        repeat (512) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (fill_banks !== 2'd1 || wr_room !== 1'b1 || rd_ptr_out !== 10'd512) begin
            errors++;
            $display("FAIL t3_half fill=%0d room=%b rp=%0d want 1 1 512", fill_banks, wr_room, rd_ptr_out);
        end
        repeat (512) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (fill_banks !== 2'd0 || rd_ptr_out !== '0 || rd_avail !== 1'b0) begin
            errors++;
            $display("FAIL t3_wrap fill=%0d rp=%0d avail=%b want 0 0 0", fill_banks, rd_ptr_out, rd_avail);
        end
    endtask

    task automatic test_underflow();
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (unf !== 1'b1 || unf_cnt !== 8'd1 || rd_ptr_out !== '0) begin
            errors++;
            $display("FAIL t4_unf unf=%b cnt=%0d rp=%0d want 1 1 0", unf, unf_cnt, rd_ptr_out);
        end
        repeat (300) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (unf_cnt !== 8'd255 || rd_ptr_out !== '0) begin
            errors++;
            $display("FAIL t4_sat cnt=%0d rp=%0d want 255 0", unf_cnt, rd_ptr_out);
        end
    endtask

    task automatic test_same_cycle_done();
        do_flush();
        repeat (64) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (511) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (63) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (fill_banks !== 2'd1 || rd_ptr_out !== 10'd511 || wr_ptr_out !== 10'd1016) begin
            errors++;
            $display("FAIL t5_setup fill=%0d rp=%0d wp=%0d want 1 511 1016",
                     fill_banks, rd_ptr_out, wr_ptr_out);
        end
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (fill_banks !== 2'd1 || wr_ptr_out !== '0 || rd_ptr_out !== 10'd512) begin
            errors++;
            $display("FAIL t5_both fill=%0d wp=%0d rp=%0d want 1 0 512",
                     fill_banks, wr_ptr_out, rd_ptr_out);
        end
    endtask

    task automatic test_addr_path();
        do_flush();
        repeat (5) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (ddr_addr !== 10'd40) begin
            errors++;
            $display("FAIL t6_wr_addr got %0d want 40", ddr_addr);
        end
        // Address must be the pre-increment pointer when firing in the same cycle.
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (ddr_addr !== 10'd40 || wr_ptr_out !== 10'd48) begin
            errors++;
            $display("FAIL t6_pre_inc addr=%0d wp=%0d want 40 48", ddr_addr, wr_ptr_out);
        end
        repeat (58) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (7) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (ddr_addr !== 10'd7 || xb_refill !== 1'b1) begin
            errors++;
            $display("FAIL t6_rd_addr addr=%0d refill=%b want 7 1", ddr_addr, xb_refill);
        end
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        do_flush();
        checks++;
        if ({rd_avail, xb_refill, ovf, unf} !== 4'b0000 || ddr_addr !== '0 || fill_banks !== '0 ||
            wr_ptr_out !== '0 || rd_ptr_out !== '0 || ovf_cnt !== '0 || unf_cnt !== '0 ||
            wr_room !== 1'b1) begin
            errors++;
            $display("FAIL t6_flush addr=%0d fill=%0d wp=%0d rp=%0d refill=%b room=%b want cleared",
                     ddr_addr, fill_banks, wr_ptr_out, rd_ptr_out, xb_refill, wr_room);
        end
    endtask

    // Randomized traffic in phases of varying read/write pressure.
    task automatic test_random();
        int wp, rp;
        logic w, r, wq, e, f;
        do_flush();
        for (int ph = 0; ph < 6; ph++) begin
            wp = (ph % 3 == 0) ? 70 : ((ph % 3 == 1) ? 10 : 40);
            rp = (ph % 3 == 0) ? 30 : ((ph % 3 == 1) ? 95 : 80);
            for (int i = 0; i < 700; i++) begin
                w  = ($urandom_range(99) < wp);
                r  = ($urandom_range(99) < rp);
                wq = $urandom_range(1);
                e  = $urandom_range(1);
                f  = ($urandom_range(999) == 0);
                cyc(w, r, wq, e, f);
                checks++;
                if (fill_banks !== (BANK_BITS+1)'(m_fill()) ||
                    wr_room !== (m_fill() != NB) || rd_avail !== (m_fill() != 0)) begin
                    errors++;
                    $display("FAIL rnd_fill cyc=%0d fill=%0d room=%b avail=%b want fill %0d",
                             i, fill_banks, wr_room, rd_avail, m_fill());
                end
                checks++;
                if (wr_ptr_out !== AW'(m_wr_tot % SPACE) || rd_ptr_out !== AW'(m_rd_tot % SPACE)) begin
                    errors++;
                    $display("FAIL rnd_ptr cyc=%0d wp=%0d rp=%0d want %0d %0d", i, wr_ptr_out,
                             rd_ptr_out, m_wr_tot % SPACE, m_rd_tot % SPACE);
                end
                checks++;
                if (ddr_addr !== AW'(m_addr) || xb_refill !== 1'(m_refill)) begin
                    errors++;
                    $display("FAIL rnd_addr cyc=%0d addr=%0d refill=%b want %0d %0d",
                             i, ddr_addr, xb_refill, m_addr, m_refill);
                end
                checks++;
                if (ovf !== 1'(m_ovf) || unf !== 1'(m_unf) ||
                    ovf_cnt !== CW'(m_ovf_c) || unf_cnt !== CW'(m_unf_c)) begin
                    errors++;
                    $display("FAIL rnd_err cyc=%0d ovf=%b/%0d unf=%b/%0d want %0d/%0d %0d/%0d",
                             i, ovf, ovf_cnt, unf, unf_cnt, m_ovf, m_ovf_c, m_unf, m_unf_c);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_first_bank();
        test_overflow();
        test_drain();
        test_underflow();
        test_same_cycle_done();
        test_addr_path();
        test_random();
        idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
